// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter sharing one registered WIDTH-bit valid/ready output among
// CHANNELS requesters; the grant is held for a whole packet, then priority rotates.
module rr_mux_arbiter #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int SEL_LENGTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req_valid,
  input  logic [CHANNELS-1:0]       req_last,
  input  logic [CHANNELS*WIDTH-1:0] req_data,
  output logic [CHANNELS-1:0]       req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_LENGTH-1:0]     out_sel,
  output logic                      out_last,
  output logic                      busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                state, state_next;
  logic [SEL_LENGTH-1:0] ptr, ptr_next;
  logic [SEL_LENGTH-1:0] grant, grant_next;
  logic [SEL_LENGTH-1:0] pick;
  logic [CHANNELS-1:0]   upper_valid;
  logic                  can_accept;
  logic                  xfer;
  logic                  grant_valid;
  logic                  grant_last;
  logic [WIDTH-1:0]      grant_data;

  // Scanning ptr..CHANNELS-1 then 0..ptr-1 is the same as taking the lowest valid
  // index at or above ptr, falling back to the lowest valid index overall.
  always_comb begin
    pick        = '0;
    upper_valid = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      upper_valid[i] = req_valid[i] && (SEL_LENGTH'(i) >= ptr);
    for (int unsigned i = CHANNELS; i > 0; i--)
      if (req_valid[i-1]) pick = SEL_LENGTH'(i-1);
    for (int unsigned i = CHANNELS; i > 0; i--)
      if (upper_valid[i-1]) pick = SEL_LENGTH'(i-1);
  end

  assign grant_valid = req_valid[grant];
  assign grant_last  = req_last[grant];
  assign grant_data  = req_data[grant*WIDTH +: WIDTH];
  assign can_accept  = !out_valid || out_ready;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = grant;
    req_ready  = '0;
    busy       = 1'b0;
    xfer       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_next = pick;
          state_next = LOCK;
        end
      end
      LOCK: begin
        busy             = 1'b1;
        req_ready[grant] = can_accept;
        xfer             = grant_valid && can_accept;
        if (xfer && grant_last) begin
          state_next = IDLE;
          ptr_next   = (grant == SEL_LENGTH'(CHANNELS-1)) ? '0 : grant + SEL_LENGTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      grant <= grant_next;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        out_last  <= grant_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed packet sources feed a 4-channel instance,
// a monitor checks accepted output beats against hand-ordered expectations.
module tb_rr_mux_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           out_valid, out_ready, out_last, busy;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_sel;

  logic [2:0]  v3, l3, rdy3, f3;
  logic [23:0] d3;
  logic        ov3, or3, ol3, busy3;
  logic [7:0]  od3;
  logic [1:0]  os3;

  typedef struct packed { logic [7:0] data; logic last; logic [1:0] sel; } beat_t;
  typedef struct { logic [7:0] data; logic last; int gap; } src_t;

  src_t  src_q [N][$];
  beat_t exp_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    chk_gap  = 1'b0;
  int    last_acc = -1;

  rr_mux_arbiter #(.WIDTH(W), .CHANNELS(N), .SEL_LENGTH(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_last(out_last), .busy(busy));

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(3), .SEL_LENGTH(2)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_last(l3), .req_data(d3),
    .req_ready(rdy3), .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .out_sel(os3), .out_last(ol3), .busy(busy3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic send(input int ch, input logic [7:0] data, input logic last, input int gap);
    src_t s;
    s.data = data; s.last = last; s.gap = gap;
    src_q[ch].push_back(s);
  endtask

  task automatic expect_beat(input logic [7:0] data, input logic last, input logic [1:0] sel);
    beat_t b;
    b.data = data; b.last = last; b.sel = sel;
    exp_q.push_back(b);
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int i = 0; i < N; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic drain(input string name);
    int c;
    c = 0;
    while (pending() > 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    check({name, "_drained"}, pending(), 0);
    @(posedge clk); #2;
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_valid"}, out_valid, 0);
  endtask

  // Source driver: presents queue heads at negedge, pops beats seen accepted at posedge.
  initial begin
    logic [N-1:0] fire;
    src_t s;
    req_valid = '0; req_last = '0; req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = 1'b0; req_last[i] = 1'b0; req_data[i*W +: W] = '0;
        if (src_q[i].size() > 0) begin
          if (src_q[i][0].gap > 0) begin
            s = src_q[i].pop_front(); s.gap--; src_q[i].push_front(s);
          end else begin
            req_valid[i] = 1'b1; req_last[i] = src_q[i][0].last; req_data[i*W +: W] = src_q[i][0].data;
          end
        end
      end
      #4 fire = req_valid & req_ready;
      @(posedge clk);
      for (int i = 0; i < N; i++)
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  end

  // Output monitor.
  initial begin
    logic  held;
    beat_t hb, act, e;
    int    cyc;
    held = 1'b0; cyc = 0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      act = {out_data, out_last, out_sel};
      if (rst) held = 1'b0;
      else begin
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_fields", act, hb);
        end
        if (out_valid && !out_ready) check("stall_req_ready", req_ready, 0);
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat: got data=%0h last=%0b sel=%0d, expected no beat", out_data, out_last, out_sel);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              n_fail++;
              $display("FAIL beat: got data=%0h last=%0b sel=%0d, expected data=%0h last=%0b sel=%0d",
                       out_data, out_last, out_sel, e.data, e.last, e.sel);
            end
          end
          if (chk_gap && last_acc >= 0) check("beat_spacing", cyc - last_acc, 2);
          last_acc = cyc;
        end
        held = out_valid && !out_ready;
        hb   = act;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int nb;
    rst = 1'b1; out_ready = 1'b1;
    v3 = '0; l3 = '0; d3 = '0; or3 = 1'b1; f3 = '0;
    repeat (2) @(posedge clk); #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;

    // All four valid, single-beat packets: grants 0,1,2,3,0 on alternate cycles.
    @(posedge clk); #2;
    chk_gap = 1'b1; last_acc = -1;
    send(0, 8'h10, 1, 0); send(0, 8'h50, 1, 0);
    send(1, 8'h11, 1, 0); send(2, 8'h12, 1, 0); send(3, 8'h13, 1, 0);
    expect_beat(8'h10, 1, 0); expect_beat(8'h11, 1, 1); expect_beat(8'h12, 1, 2);
    expect_beat(8'h13, 1, 3); expect_beat(8'h50, 1, 0);
    drain("rr4");
    chk_gap = 1'b0;

    // Single requester ch2, three beats, with latency checks (ptr now 1).
    send(2, 8'hA1, 0, 0); send(2, 8'hA2, 0, 0); send(2, 8'hA3, 1, 0);
    expect_beat(8'hA1, 0, 2); expect_beat(8'hA2, 0, 2); expect_beat(8'hA3, 1, 2);
    @(negedge clk); #2;
    check("lat_c0_req_ready", req_ready, 4'b0000);
    check("lat_c0_busy", busy, 0);
    @(posedge clk); #2;
    check("lat_c1_req_ready", req_ready, 4'b0100);
    check("lat_c1_out_valid", out_valid, 0);
    @(posedge clk); #2;
    check("lat_c2_out_valid", out_valid, 1);
    check("lat_c2_out_data", out_data, 8'hA1);
    drain("single");

    // ch3 wins from ptr=3, gaps mid-packet; ch1 must wait for ch3's last beat.
    send(3, 8'hC1, 0, 0); send(3, 8'hC2, 0, 2); send(3, 8'hC3, 1, 0);
    send(1, 8'hB1, 1, 0);
    expect_beat(8'hC1, 0, 3); expect_beat(8'hC2, 0, 3); expect_beat(8'hC3, 1, 3);
    expect_beat(8'hB1, 1, 1);
    drain("gap");

    // Backpressure for three cycles in the middle of a ch0 packet.
    send(0, 8'hD0, 0, 0); send(0, 8'hD1, 0, 0); send(0, 8'hD2, 0, 0); send(0, 8'hD3, 1, 0);
    expect_beat(8'hD0, 0, 0); expect_beat(8'hD1, 0, 0); expect_beat(8'hD2, 0, 0);
    expect_beat(8'hD3, 1, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #2;
      seen = out_valid;
    end
    check("bp_first_beat_seen", seen, 1);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 out_ready = 1'b1;
    drain("backpressure");

    // Reset after two of four ch1 beats; the next grant must come from ptr=0.
    send(1, 8'hE0, 0, 0); send(1, 8'hE1, 0, 0); send(1, 8'hE2, 0, 0); send(1, 8'hE3, 1, 0);
    expect_beat(8'hE0, 0, 1); expect_beat(8'hE1, 0, 1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #2;
      seen = (src_q[1].size() == 2);
    end
    check("midpkt_two_sent", seen, 1);
    rst = 1'b1;
    src_q[1].delete();
    #1;
    check("midpkt_rst_out_valid", out_valid, 0);
    check("midpkt_rst_busy", busy, 0);
    check("midpkt_rst_req_ready", req_ready, 0);
    check("midpkt_beats_before_rst", exp_q.size(), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    send(0, 8'hF0, 1, 0); send(1, 8'hF1, 1, 0);
    expect_beat(8'hF0, 1, 0); expect_beat(8'hF1, 1, 1);
    drain("post_rst");

    // Three-channel instance: ptr wraps to 0 after ch2, then random traffic.
    @(posedge clk); #2;
    v3 = 3'b100; l3 = 3'b111; d3 = {8'hC2, 16'h0000};
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk); #3;
      seen = v3[2] && rdy3[2];
      @(posedge clk); #2;
    end
    check("c3_ch2_fire", seen, 1);
    v3 = 3'b011; d3 = {8'h00, 8'hB1, 8'hB0};
    nb = 0;
    for (int c = 0; c < 20 && nb < 2; c++) begin
      @(negedge clk); #1;
      if (ov3) begin
        if (nb == 0) begin
          check("c3_first_sel", os3, 2);
          check("c3_first_data", od3, 8'hC2);
          check("c3_first_last", ol3, 1);
          check("c3_first_busy", busy3, 0);
        end else begin
          check("c3_wrap_sel", os3, 0);
          check("c3_wrap_data", od3, 8'hB0);
        end
        nb++;
      end
    end
    check("c3_beats_seen", nb, 2);

    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #3;
      f3 = v3 & rdy3;
      if (ov3) check("c3_sel_range", os3 < 2'd3, 1);
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) begin
        if (f3[i] || !v3[i]) begin
          v3[i] = 1'($urandom_range(0, 1));
          l3[i] = 1'($urandom_range(0, 1));
          d3[i*8 +: 8] = 8'($urandom);
        end
      end
      or3 = ($urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a CHANNELS-way, WIDTH-bit multiplexed datapath among CHANNELS requesters.
- Each requester offers packets of one or more beats over a valid/ready handshake with a last marker.
- The arbiter locks the mux select to one requester for a whole packet, then rotates priority.
- Output is a registered single-stage valid/ready stream carrying data, source index and last; it feeds ALU operand/result buses.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of requesters (>=2; need not be a power of two).
- SEL_LENGTH, 2, select/index width; must satisfy 2^SEL_LENGTH >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  CHANNELS  bit i: requester i has a beat on its data slice.
- req_last  input  CHANNELS  bit i: current beat of requester i ends its packet.
- req_data  input  CHANNELS*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  CHANNELS  bit i: beat of requester i accepted this cycle if valid.
- out_valid  output  1  out_data/out_sel/out_last hold a beat.
- out_ready  input  1  downstream accepts the output beat.
- out_data  output  WIDTH  registered selected beat.
- out_sel  output  SEL_LENGTH  index of the channel that produced out_data.
- out_last  output  1  registered last marker.
- busy  output  1  arbiter is locked to a requester (state LOCK).

Behaviour:
- Reset (async assert, any time): state=IDLE, ptr=0, grant=0, out_valid=0, out_data=0, out_sel=0, out_last=0, busy=0, req_ready=0. Any in-flight packet is dropped; no partial state survives.
- States: IDLE, LOCK.
- IDLE:
  - req_ready=0.
  - If any req_valid, grant = first set bit scanning ptr, ptr+1, ... wrapping at CHANNELS-1 -> 0. Go to LOCK next edge.
  - If no req_valid, stay IDLE; ptr unchanged.
- LOCK:
  - busy=1.
  - req_ready[grant] = (!out_valid || out_ready); all other req_ready bits are 0.
  - Transfer = req_valid[grant] && req_ready[grant]. On transfer, register out_data = req_data slice[grant], out_sel = grant, out_last = req_last[grant], out_valid=1.
  - Transfer with req_last[grant]=1: next state IDLE; ptr = grant+1, wrapping to 0 when grant = CHANNELS-1.
  - Requester drops valid mid-packet: stay LOCK, no beats from others, no timeout.
- Output register:
  - out_valid && out_ready && no transfer -> out_valid=0; data fields hold their last value.
  - out_ready and transfer in the same cycle -> new beat replaces old; out_valid stays 1. Full throughput: 1 beat/cycle while locked.
  - out_valid && !out_ready -> all output fields stable; req_ready=0.
- Latency:
  - Req valid in IDLE at cycle 0 -> req_ready at cycle 1 -> out_valid at cycle 2.
  - One dead cycle per packet for arbitration (IDLE). Single-beat packets therefore sustain 1 beat per 2 cycles.
- Fairness: a requester continuously valid is granted within CHANNELS packets.
- Index arithmetic is modulo CHANNELS, not 2^SEL_LENGTH. Indices >= CHANNELS are never produced.
- req_data/req_last of non-granted channels are ignored. The handshake requires valid to stay stable until ready; the arbiter does not check this.

Test Plan:
- Reset mid-packet: ch1 locked, 2 of 4 beats sent, rst pulse -> out_valid=0, busy=0, ptr=0. Next grant is ch0 if ch0 is valid.
- Single requester: ch2 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd), out_ready=1 -> req_ready[2] high cycles 1-3; out_data A1,A2,A3 on cycles 2-4, out_sel=2, out_last only on A3. Then IDLE with ptr=3.
- All four valid, single-beat packets, CHANNELS=4 -> grant order 0,1,2,3,0. out_valid every other cycle.
- Backpressure: out_ready=0 for 3 cycles during ch0 packet -> req_ready[0]=0 and out_data frozen. Resume with no loss or duplication.
- Mid-packet valid gap: ch3 lock, ch3 drops valid 2 cycles while ch1 valid -> no ch1 beats until ch3 last. Then ptr wraps to 0 and ch1 is granted.
- CHANNELS=3, SEL_LENGTH=2: ch2 last accepted -> ptr=0. out_sel never equals 3 over a random 1000-cycle run.
